// File: rtl/rep_sub_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
package rep_sub_pkg;

    localparam int WIDTH_DEFAULT = 8;

    // Wide all-ones pattern; the divider slices it to its own WIDTH (up to 64 bits).
    localparam logic [63:0] QUO_DIV0_FULL = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/rep_sub_divider_if.sv
// START/DONE handshake and operand/result bus between the controlling FSM and the divider.
interface rep_sub_divider_if #(
    parameter int WIDTH = 8
);

    logic             START;
    logic [WIDTH-1:0] DVND;
    logic [WIDTH-1:0] DVSR;
    logic [WIDTH-1:0] QUO;
    logic [WIDTH-1:0] REM;
    logic             BUSY;
    logic             DONE;
    logic             DIV0;

    modport master (
        output START, DVND, DVSR,
        input  QUO, REM, BUSY, DONE, DIV0
    );

    modport slave (
        input  START, DVND, DVSR,
        output QUO, REM, BUSY, DONE, DIV0
    );

endinterface

// File: rtl/sub_step.sv
// One compare/subtract step: flags rem >= divisor and offers rem - divisor.
module sub_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    output logic             ge,
    output logic [WIDTH-1:0] diff
);

    assign ge   = (rem >= divisor);
    assign diff = rem - divisor;

endmodule

// File: rtl/rep_sub_divider.sv
// Sequential unsigned divider: subtracts the latched divisor once per cycle until
// the remainder drops below it, counting subtractions as the quotient.
module rep_sub_divider
    import rep_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                CLR,
    rep_sub_divider_if.slave    bus
);

    localparam logic [WIDTH-1:0] QUO_DIV0 = QUO_DIV0_FULL[WIDTH-1:0];

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic             div0;
    logic             ge;
    logic [WIDTH-1:0] diff;

    sub_step #(
        .WIDTH (WIDTH)
    ) u_sub_step (
        .rem     (rem),
        .divisor (divisor),
        .ge      (ge),
        .diff    (diff)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.START) begin
                    state_nxt = (bus.DVSR == '0) ? FIN : SUB;
                end
            end
            SUB: begin
                if (!ge) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are captured only on an accepted START; later bus changes are ignored.
    always_ff @(posedge clk) begin
        if (CLR) begin
            state   <= IDLE;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            div0    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        rem     <= bus.DVND;
                        divisor <= bus.DVSR;
                        if (bus.DVSR == '0) begin
                            quo  <= QUO_DIV0;
                            div0 <= 1'b1;
                        end else begin
                            quo  <= '0;
                            div0 <= 1'b0;
                        end
                    end
                end
                SUB: begin
                    if (ge) begin
                        rem <= diff;
                        quo <= quo + WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.QUO  = quo;
    assign bus.REM  = rem;
    assign bus.DIV0 = div0;
    assign bus.BUSY = (state != IDLE);
    assign bus.DONE = (state == FIN);

endmodule

// File: tb/tb_rep_sub_divider.sv
// Self-checking bench for rep_sub_divider against a plain-arithmetic division model.
module tb_rep_sub_divider;

    logic clk;
    logic CLR;
    int   checks;
    int   errors;

    rep_sub_divider_if #(.WIDTH(8)) bif ();

    rep_sub_divider #(
        .WIDTH (8)
    ) dut (
        .clk (clk),
        .CLR (CLR),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called #1 after an edge while the divider is idle; returns #1 after the sampling edge.
    task automatic start_op(input int a, input int b);
        bif.START = 1'b1;
        bif.DVND  = 8'(a);
        bif.DVSR  = 8'(b);
        @(posedge clk);
        #1;
        bif.START = 1'b0;
        bif.DVND  = 8'($urandom);
        bif.DVSR  = 8'($urandom);
    endtask

    // Waits for DONE and compares against a/b computed directly; optional mid-run START glitch.
    task automatic wait_done(input string tag, input int a, input int b, input bit glitch);
        int exp_q;
        int exp_r;
        int exp_lat;
        int edges;
        bit exp_d0;
        exp_d0  = (b == 0);
        exp_q   = (b == 0) ? 255 : a / b;
        exp_r   = (b == 0) ? a : a % b;
        exp_lat = (b == 0) ? 0 : a / b + 1;
        edges   = 0;
        for (int k = 0; k < 300; k++) begin
            if (bif.DONE === 1'b1) break;
            check({tag, "_busy"}, 32'(bif.BUSY), 32'd1);
            @(posedge clk);
            #1;
            edges++;
            if (glitch && edges == 3) begin
                bif.START = 1'b1;
                bif.DVND  = 8'd10;
                bif.DVSR  = 8'd2;
            end
            if (glitch && edges == 4) begin
                bif.START = 1'b0;
                bif.DVSR  = 8'd1;
            end
        end
        if (bif.DONE !== 1'b1) begin
            check({tag, "_timeout"}, 32'(edges), 32'(exp_lat));
            return;
        end
        check({tag, "_lat"},  32'(edges),     32'(exp_lat));
        check({tag, "_quo"},  32'(bif.QUO),   32'(exp_q));
        check({tag, "_rem"},  32'(bif.REM),   32'(exp_r));
        check({tag, "_div0"}, 32'(bif.DIV0),  32'(exp_d0));
        check({tag, "_busyd"}, 32'(bif.BUSY), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(bif.DONE), 32'd0);
        check({tag, "_busy_idle"},  32'(bif.BUSY), 32'd0);
        check({tag, "_quo_hold"},   32'(bif.QUO),  32'(exp_q));
        check({tag, "_rem_hold"},   32'(bif.REM),  32'(exp_r));
        check({tag, "_div0_hold"},  32'(bif.DIV0), 32'(exp_d0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_quo"},  32'(bif.QUO),  32'd0);
        check({tag, "_rem"},  32'(bif.REM),  32'd0);
        check({tag, "_busy"}, 32'(bif.BUSY), 32'd0);
        check({tag, "_done"}, 32'(bif.DONE), 32'd0);
        check({tag, "_div0"}, 32'(bif.DIV0), 32'd0);
    endtask

    initial begin
        bit seen_done;
        int a;
        int b;
        checks    = 0;
        errors    = 0;
        CLR       = 1'b1;
        bif.START = 1'b0;
        bif.DVND  = '0;
        bif.DVSR  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // START together with CLR must not be accepted.
        bif.START = 1'b1;
        bif.DVND  = 8'd100;
        bif.DVSR  = 8'd3;
        @(posedge clk);
        #1;
        CLR       = 1'b0;
        bif.START = 1'b0;
        check_reset_outputs("clr_start");
        @(posedge clk);
        #1;
        check("clr_start_idle", 32'(bif.BUSY), 32'd0);

        start_op(200, 7);  wait_done("d200_7", 200, 7, 1'b0);
        start_op(5, 9);    wait_done("d5_9", 5, 9, 1'b0);
        start_op(0, 3);    wait_done("d0_3", 0, 3, 1'b0);
        start_op(255, 1);  wait_done("d255_1", 255, 1, 1'b0);
        start_op(255, 255); wait_done("d255_255", 255, 255, 1'b0);
        start_op(42, 0);   wait_done("d42_0", 42, 0, 1'b0);
        start_op(42, 6);   wait_done("d42_6", 42, 6, 1'b0);
        start_op(200, 7);  wait_done("glitch", 200, 7, 1'b1);

        // Abort mid-division with CLR; no DONE may follow.
        start_op(200, 7);
        repeat (9) @(posedge clk);
        #1;
        CLR = 1'b1;
        @(posedge clk);
        #1;
        CLR = 1'b0;
        check_reset_outputs("abort");
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bif.DONE === 1'b1) seen_done = 1'b1;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        start_op(9, 4);    wait_done("d9_4", 9, 4, 1'b0);

        // START held high: a second division starts in the first IDLE cycle after FIN.
        bif.START = 1'b1;
        bif.DVND  = 8'd20;
        bif.DVSR  = 8'd6;
        @(posedge clk);
        #1;
        bif.DVND  = 8'd50;
        bif.DVSR  = 8'd8;
        wait_done("held1", 20, 6, 1'b0);
        @(posedge clk);
        #1;
        bif.START = 1'b0;
        wait_done("held2", 50, 8, 1'b0);

        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 255));
            b = (i % 4 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
            start_op(a, b);
            wait_done($sformatf("rnd%0d", i), a, b, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
